// File: rtl/button_io_regs.sv
// rtl/button_io_regs.sv - button input synchronizer/debouncer with event register file
//
// Purpose: synchronizes raw button inputs, optionally debounces them, records
// press/release/vblank-start sticky events, and exposes them plus the display
// status through a small strobe-based register interface with a level IRQ.
//
// Configuration macro: BUTTON_DEBOUNCE_EN (defined = per-button debounce
// counters compiled in; undefined = debounced level is the synchronizer output).
//
// Ports:
//   clk                  in   system clock, rising edge
//   reset_n              in   synchronous active-low reset
//   buttons              in   raw asynchronous buttons, 1 = pressed
//   in_vblank_i          in   vertical-blank flag (clk domain)
//   collision_i          in   sprite collision flags (clk domain)
//   register_index       in   register address
//   register_read        in   read strobe
//   register_write       in   write strobe
//   register_write_value in   write data
//   register_read_value  out  registered read data
//   irq_o                out  level interrupt: any masked press/release pending

module button_io_regs #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   in_vblank_i,
  input  logic [5:0]             collision_i,
  input  logic [11:0]            register_index,
  input  logic                   register_read,
  input  logic                   register_write,
  input  logic [15:0]            register_write_value,
  output logic [15:0]            register_read_value,
  output logic                   irq_o
);

  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] level_prev_q;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] mask_q, mask_d;
  logic                   vblank_prev_q;
  logic                   vblank_start_q, vblank_start_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   irq_q, irq_d;
  logic                   rd1, rd3, rd4, wr5;
  logic                   unused_wdata;

  // Only the low NUM_BUTTONS bits of the write data reach the mask.
  assign unused_wdata = ^register_write_value;

  // Two-flop synchronizer; nothing downstream sees the raw inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];

  // Counter runs only while the input disagrees with the accepted level; it
  // resets on any agreement, so a bouncing input never reaches CNT_MAX and
  // the counter is cleared on acceptance rather than wrapping.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level = level_q;
`else
  logic unused_cfg;

  // Debounce compiled out: the synchronizer output is the accepted level.
  assign level      = sync2_q;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
`endif

  assign rd1 = register_read  && (register_index == 12'd1);
  assign rd3 = register_read  && (register_index == 12'd3);
  assign rd4 = register_read  && (register_index == 12'd4);
  assign wr5 = register_write && (register_index == 12'd5);

  always_comb begin
    // Clear-on-read drops exactly what the read returned (the whole register);
    // new events are OR-ed in afterwards so a coincident event survives.
    press_d        = (rd3 ? '0 : press_q)   | (level & ~level_prev_q);
    release_d      = (rd4 ? '0 : release_q) | (~level & level_prev_q);
    vblank_start_d = (rd1 ? 1'b0 : vblank_start_q) | (in_vblank_i & ~vblank_prev_q);
    mask_d         = wr5 ? register_write_value[NUM_BUTTONS-1:0] : mask_q;
    irq_d          = |((press_q | release_q) & mask_q);

    // Read data samples current state, so a same-cycle write to 5 returns
    // the old mask.
    rdata_d = rdata_q;
    if (register_read) begin
      case (register_index)
        12'd0:   rdata_d = 16'(level);
        12'd1:   rdata_d = {14'b0, vblank_start_q, in_vblank_i};
        12'd2:   rdata_d = {10'b0, collision_i};
        12'd3:   rdata_d = 16'(press_q);
        12'd4:   rdata_d = 16'(release_q);
        12'd5:   rdata_d = 16'(mask_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_prev_q   <= '0;
      press_q        <= '0;
      release_q      <= '0;
      mask_q         <= '0;
      vblank_prev_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      rdata_q        <= '0;
      irq_q          <= 1'b0;
    end else begin
      level_prev_q   <= level;
      press_q        <= press_d;
      release_q      <= release_d;
      mask_q         <= mask_d;
      vblank_prev_q  <= in_vblank_i;
      vblank_start_q <= vblank_start_d;
      rdata_q        <= rdata_d;
      irq_q          <= irq_d;
    end
  end

  assign register_read_value = rdata_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_button_io_regs.sv
// tb/tb_button_io_regs.sv - directed self-checking bench for button_io_regs

module tb_button_io_regs;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int PRESS_LAT = 7;
`else
  localparam int PRESS_LAT = 3;
`endif
  localparam int SETTLE = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  buttons;
  logic        in_vblank_i;
  logic [5:0]  collision_i;
  logic [11:0] register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] rv;

  button_io_regs #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .buttons              (buttons),
    .in_vblank_i          (in_vblank_i),
    .collision_i          (collision_i),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .irq_o                (irq_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] idx, output logic [15:0] val);
    register_index = idx;
    register_read  = 1'b1;
    tick();
    register_read  = 1'b0;
    val = register_read_value;
  endtask

  task automatic wr(input logic [11:0] idx, input logic [15:0] val);
    register_index       = idx;
    register_write       = 1'b1;
    register_write_value = val;
    tick();
    register_write       = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; buttons = '0; in_vblank_i = 1'b0; collision_i = '0;
    register_index = '0; register_read = 1'b0; register_write = 1'b0;
    register_write_value = '0;
    tick(3);
    check("reset_rdata", register_read_value, 16'h0000);
    check("reset_irq", {15'b0, irq_o}, 16'h0000);
    reset_n = 1'b1;
    tick(2);
    rd(12'd0, rv); check("idle_level", rv, 16'h0000);
    rd(12'd5, rv); check("idle_mask", rv, 16'h0000);

`ifdef BUTTON_DEBOUNCE_EN
    buttons = 4'b0001;
    tick(20);
    rd(12'd0, rv); check("db_level", rv, 16'h0001);
    rd(12'd3, rv); check("db_press", rv, 16'h0001);
    rd(12'd3, rv); check("db_press_clr", rv, 16'h0000);
    buttons = 4'b0000;
    tick(SETTLE);
    rd(12'd4, rv); check("db_release", rv, 16'h0001);
    wr(12'd5, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      buttons[0] = ~buttons[0];
      tick(); check("bounce_irq", {15'b0, irq_o}, 16'h0000);
      tick(); check("bounce_irq", {15'b0, irq_o}, 16'h0000);
    end
    tick(4);
    rd(12'd0, rv); check("bounce_level", rv, 16'h0000);
    rd(12'd3, rv); check("bounce_press", rv, 16'h0000);
    wr(12'd5, 16'h0000);
`else
    buttons = 4'b1000;
    tick(2);
    rd(12'd0, rv); check("nodb_level_3cyc", rv, 16'h0008);
    tick(2);
    rd(12'd3, rv); check("nodb_press", rv, 16'h0008);
    rd(12'd3, rv); check("nodb_press_clr", rv, 16'h0000);
    buttons = 4'b0000;
    tick(5);
    rd(12'd4, rv); check("nodb_release", rv, 16'h0008);
    check("nodb_irq_masked", {15'b0, irq_o}, 16'h0000);
`endif

    // Same-cycle read and write of the mask: read sees the old value.
    register_index = 12'd5; register_read = 1'b1; register_write = 1'b1;
    register_write_value = 16'h0002;
    tick();
    register_read = 1'b0; register_write = 1'b0;
    check("rw_old_mask", register_read_value, 16'h0000);
    rd(12'd5, rv); check("mask_new", rv, 16'h0002);

    buttons = 4'b0010;
    tick(SETTLE);
    check("irq_press", {15'b0, irq_o}, 16'h0001);
    buttons = 4'b0000;
    tick(SETTLE);
    rd(12'd3, rv); check("press_b1", rv, 16'h0002);
    tick();
    check("irq_release_pending", {15'b0, irq_o}, 16'h0001);
    rd(12'd4, rv); check("release_b1", rv, 16'h0002);
    check("irq_before_fall", {15'b0, irq_o}, 16'h0001);
    tick();
    check("irq_fall", {15'b0, irq_o}, 16'h0000);

    // Press event lands on the same edge as the clearing read.
    buttons = 4'b0100;
    tick(PRESS_LAT - 1);
    rd(12'd3, rv); check("press_coincident", rv, 16'h0000);
    rd(12'd3, rv); check("press_survives", rv, 16'h0004);
    buttons = 4'b0000;
    tick(SETTLE);
    rd(12'd4, rv); check("release_b2", rv, 16'h0004);

    in_vblank_i = 1'b1; collision_i = 6'h21;
    tick(2);
    rd(12'd1, rv); check("vblank_start", rv, 16'h0003);
    rd(12'd1, rv); check("vblank_clr", rv, 16'h0001);
    rd(12'd2, rv); check("collision", rv, 16'h0021);
    rd(12'd7, rv); check("unmapped_7", rv, 16'h0000);
    rd(12'hFFF, rv); check("unmapped_fff", rv, 16'h0000);
    wr(12'd6, 16'hFFFF);
    wr(12'd3, 16'hFFFF);
    rd(12'd5, rv); check("ignored_write_mask", rv, 16'h0002);
    rd(12'd3, rv); check("ignored_write_press", rv, 16'h0000);

    // Button held through a one-cycle reset.
    in_vblank_i = 1'b0; collision_i = '0;
    wr(12'd5, 16'h000F);
    buttons = 4'b1000;
    tick(SETTLE);
    check("irq_before_reset", {15'b0, irq_o}, 16'h0001);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("reset2_irq", {15'b0, irq_o}, 16'h0000);
    check("reset2_rdata", register_read_value, 16'h0000);
    rd(12'd5, rv); check("reset2_mask", rv, 16'h0000);
    rd(12'd3, rv); check("reset2_press", rv, 16'h0000);
    rd(12'd1, rv); check("reset2_vblank", rv, 16'h0000);
    tick(SETTLE);
    rd(12'd3, rv); check("press_after_reset", rv, 16'h0008);
    rd(12'd0, rv); check("level_after_reset", rv, 16'h0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
